usb_tx_encoder: RTL

Serial transmit back end for the USB full-speed link, the transmit-side counterpart of the RX edge-detect/decode path. It accepts packet bytes over a valid/ready handshake and prepends the SYNC byte. It then serializes LSB-first, applies bit stuffing and NRZI encoding, and drives d_plus/d_minus, finishing each packet with an EOP. It sits between the TX packet controller (byte source) and the pad drivers.

---
 rtl/usb_tx_pkg.sv | 28 ++
 rtl/usb_tx_bit_timer.sv | 29 ++
 rtl/usb_tx_encoder.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed TX encoder.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP_SE0,
    ST_EOP_J
  } tx_state_e;

  localparam logic [7:0] SYNC_BYTE   = 8'h80;
  localparam logic [2:0] STUFF_LIMIT = 3'd6;

  // Encoded as {d_plus, d_minus}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  function automatic logic [1:0] nrzi(
    input logic [1:0] line,
    input logic       b
  );
    if (b) return line;
    return (line == LINE_J) ? LINE_K : LINE_J;
  endfunction

endpackage

// File: rtl/usb_tx_bit_timer.sv
// Bit-time counter; bit_end_o marks the last clock of each bit.
module usb_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr_i,
  output logic bit_end_o
);

  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] TERM = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign bit_end_o = (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || bit_end_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/usb_tx_encoder.sv
// USB FS transmit back end: SYNC, bit stuffing, NRZI and EOP.
module usb_tx_encoder
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       d_plus,
  output logic       d_minus,
  output logic       tx_busy,
  output logic       tx_underrun
);

  tx_state_e  state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_last_q, hold_last_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] idx_q, idx_d;
  logic       last_q, last_d;
  logic [2:0] ones_q, ones_d;
  logic [1:0] line_q, line_d;

  logic       bit_end;
  logic       timer_clr;
  logic [2:0] idx_inc;
  logic       do_stuff;
  logic       do_adv;
  logic       at_bnd;
  logic       emit;
  logic       nbit;
  logic       under_c;

  assign timer_clr = (state_q == ST_IDLE);
  assign idx_inc   = idx_q + 3'd1;
  assign do_stuff  = (ones_q == STUFF_LIMIT);
  assign do_adv    = !do_stuff && (idx_q != 3'd7);
  assign at_bnd    = !do_stuff && (idx_q == 3'd7);

  usb_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .clr_i    (timer_clr),
    .bit_end_o(bit_end)
  );

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_last_d = hold_last_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    last_d      = last_q;
    ones_d      = ones_q;
    line_d      = line_q;
    emit        = 1'b0;
    nbit        = 1'b0;
    under_c     = 1'b0;

    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_last_d = tx_last;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          state_d = ST_SYNC;
          shift_d = SYNC_BYTE;
          idx_d   = 3'd0;
          last_d  = 1'b0;
          ones_d  = {2'b00, SYNC_BYTE[0]};
          line_d  = nrzi(LINE_J, SYNC_BYTE[0]);
        end
      end
      ST_SYNC, ST_DATA: begin
        if (bit_end) begin
          // Stuff bit takes priority; the byte boundary waits for it.
          unique case (1'b1)
            do_stuff: begin
              emit = 1'b1;
            end
            do_adv: begin
              emit  = 1'b1;
              nbit  = shift_q[idx_inc];
              idx_d = idx_inc;
            end
            at_bnd && last_q: begin
              state_d = ST_EOP_SE0;
              line_d  = LINE_SE0;
              idx_d   = 3'd0;
            end
            at_bnd && !last_q && hold_full_q: begin
              state_d     = ST_DATA;
              shift_d     = hold_q;
              last_d      = hold_last_q;
              hold_full_d = 1'b0;
              idx_d       = 3'd0;
              emit        = 1'b1;
              nbit        = hold_q[0];
            end
            at_bnd && !last_q && !hold_full_q: begin
              under_c = 1'b1;
              state_d = ST_EOP_SE0;
              line_d  = LINE_SE0;
              idx_d   = 3'd0;
            end
            default: ;
          endcase
        end
      end
      ST_EOP_SE0: begin
        if (bit_end) begin
          if (idx_q == 3'd0) begin
            idx_d = 3'd1;
          end else begin
            state_d = ST_EOP_J;
            line_d  = LINE_J;
          end
        end
      end
      ST_EOP_J: begin
        if (bit_end) begin
          state_d = ST_IDLE;
          ones_d  = 3'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (emit) begin
      line_d = nrzi(line_q, nbit);
      ones_d = nbit ? ones_q + 3'd1 : 3'd0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      hold_q      <= 8'h00;
      hold_last_q <= 1'b0;
      hold_full_q <= 1'b0;
      shift_q     <= 8'h00;
      idx_q       <= 3'd0;
      last_q      <= 1'b0;
      ones_q      <= 3'd0;
      line_q      <= LINE_J;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_last_q <= hold_last_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      ones_q      <= ones_d;
      line_q      <= line_d;
    end
  end

  assign tx_ready    = !hold_full_q;
  assign tx_busy     = (state_q != ST_IDLE);
  assign tx_underrun = under_c;
  assign d_plus      = line_q[1];
  assign d_minus     = line_q[0];

endmodule
